// File: rtl/link_scheduler.sv
// Round-robin scheduler that lends one linked handshake worker to N_REQ requesters,
// re-arming the worker through its active-low reset after every job.
module link_scheduler #(
   parameter int N_REQ     = 4,
   parameter int TO_CYCLES = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [N_REQ-1:0] REQ,
   output logic [N_REQ-1:0] GNT,
   output logic [N_REQ-1:0] DONE,
   output logic [N_REQ-1:0] ERR,
   output logic             BUSY,
   output logic             W_X,
   output logic             W_NRST,
   input  logic             W_START,
   input  logic             W_Y
);

   localparam int CW = $clog2(TO_CYCLES + 1);
   localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [2:0] INIT    = 3'd0;
   localparam logic [2:0] IDLE    = 3'd1;
   localparam logic [2:0] WAIT_ST = 3'd2;
   localparam logic [2:0] RUN     = 3'd3;
   localparam logic [2:0] CLEAR   = 3'd4;
   localparam logic [2:0] ABORT   = 3'd5;

   localparam logic [CW-1:0]    TOP    = CW'(TO_CYCLES - 1);
   localparam logic [LW-1:0]    LASTRS = LW'(N_REQ - 1);
   localparam logic [N_REQ-1:0] ONE    = {{(N_REQ-1){1'b0}}, 1'b1};

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [LW-1:0] last;
   logic [LW-1:0] pick;
   logic          pickValid;
   int            idx;

   // Search starts just after the last granted requester and wraps modulo N_REQ.
   always_comb begin
      pick      = '0;
      pickValid = 1'b0;
      idx       = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = int'(last) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!pickValid && REQ[idx]) begin
            pickValid = 1'b1;
            pick      = LW'(idx);
         end
      end
   end

   // Worker events win over the watchdog when both land in the same cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= INIT;
         GNT   <= '0;
         cnt   <= '0;
         last  <= LASTRS;
      end else begin
         case (state)
            INIT: begin
               state <= IDLE;
            end
            IDLE: begin
               if (pickValid) begin
                  GNT   <= ONE << pick;
                  last  <= pick;
                  cnt   <= '0;
                  state <= WAIT_ST;
               end
            end
            WAIT_ST: begin
               if (W_START) begin
                  cnt   <= '0;
                  state <= RUN;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (cnt == TOP) begin
                     state <= ABORT;
                  end
               end
            end
            RUN: begin
               if (W_Y) begin
                  state <= CLEAR;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (cnt == TOP) begin
                     state <= ABORT;
                  end
               end
            end
            CLEAR, ABORT: begin
               GNT   <= '0;
               state <= IDLE;
            end
            default: begin
               GNT   <= '0;
               cnt   <= '0;
               state <= INIT;
            end
         endcase
      end
   end

   // The worker's done state is sticky, so it is held in reset while reporting.
   assign DONE   = (state == CLEAR) ? GNT : '0;
   assign ERR    = (state == ABORT) ? GNT : '0;
   assign BUSY   = (state != IDLE);
   assign W_X    = (state == WAIT_ST) || (state == RUN);
   assign W_NRST = !((state == INIT) || (state == CLEAR) || (state == ABORT));

endmodule

// File: tb/tb_link_scheduler.sv
// Self-checking bench for link_scheduler: a job-level reference model plus a worker model
// that answers X with START and Y after programmable delays.
module tb_link_scheduler;

   localparam int N  = 4;
   localparam int TO = 16;

   logic         CLK;
   logic         RESET;
   logic [N-1:0] REQ;
   logic [N-1:0] GNT;
   logic [N-1:0] DONE;
   logic [N-1:0] ERR;
   logic         BUSY;
   logic         W_X;
   logic         W_NRST;
   logic         W_START;
   logic         W_Y;

   link_scheduler #(.N_REQ(N), .TO_CYCLES(TO)) dut (
      .CLK(CLK), .RESET(RESET), .REQ(REQ), .GNT(GNT), .DONE(DONE), .ERR(ERR),
      .BUSY(BUSY), .W_X(W_X), .W_NRST(W_NRST), .W_START(W_START), .W_Y(W_Y)
   );

   typedef struct packed {
      logic [N-1:0] gnt;
      logic [N-1:0] done;
      logic [N-1:0] err;
      logic         busy;
      logic         wx;
      logic         nrst;
   } rec_t;

   int   checkCount = 0;
   int   passCount  = 0;
   int   cyc        = 0;
   int   startDelay = 2;
   int   yDelay     = 3;
   rec_t plan[$];
   rec_t cur;
   bit   curIdle    = 0;
   bit   modelValid = 0;
   int   mLast      = N - 1;

   logic [N-1:0] gntLog[$];
   int           gntCyc[$];
   logic [N-1:0] doneLog[$];
   int           doneCyc[$];
   logic [N-1:0] errLog[$];
   int           errCyc[$];
   logic [N-1:0] prevGnt = '0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic rec_t mk(logic [N-1:0] g, logic [N-1:0] d, logic [N-1:0] e,
                               logic b, logic x, logic n);
      rec_t r;
      r.gnt = g; r.done = d; r.err = e; r.busy = b; r.wx = x; r.nrst = n;
      return r;
   endfunction

   function automatic int pickNext(logic [N-1:0] r, int lastIdx);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (lastIdx + k) % N;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   // A job is a run of wait cycles, optionally a run of run cycles, then one report cycle.
   function automatic void planJob(int g);
      logic [N-1:0] gv;
      bit started, finished;
      int w, r;
      gv       = N'(1 << g);
      started  = (startDelay >= 0) && (startDelay < TO);
      finished = (yDelay >= 0) && (yDelay < TO);
      w        = started ? startDelay + 1 : TO;
      for (int i = 0; i < w; i++) plan.push_back(mk(gv, '0, '0, 1'b1, 1'b1, 1'b1));
      if (started) begin
         r = finished ? yDelay + 1 : TO;
         for (int i = 0; i < r; i++) plan.push_back(mk(gv, '0, '0, 1'b1, 1'b1, 1'b1));
      end
      if (started && finished) plan.push_back(mk(gv, gv, '0, 1'b1, 1'b0, 1'b0));
      else                     plan.push_back(mk(gv, '0, gv, 1'b1, 1'b0, 1'b0));
   endfunction

   // Reference model advances once per clock using only the inputs.
   initial begin
      forever begin
         @(posedge CLK);
         if (RESET) begin
            plan.delete();
            cur        = mk('0, '0, '0, 1'b1, 1'b0, 1'b0);
            curIdle    = 0;
            mLast      = N - 1;
            modelValid = 1;
         end else if (modelValid) begin
            if (plan.size() > 0) begin
               cur     = plan.pop_front();
               curIdle = 0;
            end else if (curIdle && REQ != '0) begin
               mLast = pickNext(REQ, mLast);
               planJob(mLast);
               cur     = plan.pop_front();
               curIdle = 0;
            end else begin
               cur     = mk('0, '0, '0, 1'b0, 1'b0, 1'b1);
               curIdle = 1;
            end
         end
      end
   end

   // Worker model: START after startDelay cycles of X, sticky Y after yDelay more.
   initial begin
      int ph, xc, yc;
      ph = 0; xc = 0; yc = 0;
      W_START = 1'b0;
      W_Y     = 1'b0;
      forever begin
         @(negedge CLK);
         if (W_NRST === 1'b0) begin
            ph = 0; xc = 0; yc = 0;
            W_START = 1'b0;
            W_Y     = 1'b0;
         end else if (ph == 0) begin
            if (W_X === 1'b1) begin
               if (startDelay >= 0 && xc == startDelay) begin
                  W_START = 1'b1;
                  ph = 1;
                  yc = 0;
               end else begin
                  xc++;
               end
            end
         end else if (ph == 1) begin
            W_START = 1'b0;
            if (yDelay >= 0 && yc == yDelay) begin
               W_Y = 1'b1;
               ph  = 2;
            end else begin
               yc++;
            end
         end
      end
   end

   // Per-cycle comparison against the model, plus event logging for the directed checks.
   initial begin
      rec_t act;
      forever begin
         @(negedge CLK);
         if (modelValid) begin
            act = mk(GNT, DONE, ERR, BUSY, W_X, W_NRST);
            checkCount++;
            if (act === cur) begin
               passCount++;
            end else begin
               $display("[TB] FAIL cycle%0d outputs: got gnt=%b done=%b err=%b busy=%b wx=%b nrst=%b, want gnt=%b done=%b err=%b busy=%b wx=%b nrst=%b",
                        cyc, GNT, DONE, ERR, BUSY, W_X, W_NRST,
                        cur.gnt, cur.done, cur.err, cur.busy, cur.wx, cur.nrst);
            end
         end
         if (GNT != '0 && prevGnt == '0) begin gntLog.push_back(GNT); gntCyc.push_back(cyc); end
         if (DONE != '0) begin doneLog.push_back(DONE); doneCyc.push_back(cyc); end
         if (ERR != '0) begin errLog.push_back(ERR); errCyc.push_back(cyc); end
         prevGnt = GNT;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic applyStimulus(input logic [N-1:0] req, input int sd, input int yd);
      @(negedge CLK);
      startDelay = sd;
      yDelay     = yd;
      REQ        = req;
   endtask

   task automatic waitGrants(input int target, input string name);
      int n;
      n = 0;
      while (gntLog.size() < target && n < 400) begin
         @(negedge CLK);
         n++;
      end
      if (gntLog.size() < target) checkOutput({name, "_grant_timeout"}, gntLog.size(), target);
   endtask

   task automatic waitIdle(input string name);
      int n;
      n = 0;
      @(negedge CLK);
      while (BUSY !== 1'b0 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (BUSY !== 1'b0) checkOutput({name, "_idle_timeout"}, 32'(BUSY), 0);
      @(negedge CLK);
   endtask

   task automatic runJob(input logic [N-1:0] req, input int sd, input int yd, input string name);
      int b;
      b = gntLog.size();
      applyStimulus(req, sd, yd);
      waitGrants(b + 1, name);
      REQ = '0;
      waitIdle(name);
   endtask

   initial begin
      int b, d, e;
      RESET = 1'b1;
      REQ   = '0;

      // Reset then single job: START after 2 cycles, Y after 3 more.
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      checkOutput("init_nrst_low", 32'(W_NRST), 0);
      REQ = 4'b0001;
      @(negedge CLK);
      checkOutput("idle_nrst_high", 32'(W_NRST), 1);
      checkOutput("idle_gnt_zero", 32'(GNT), 0);
      @(negedge CLK);
      checkOutput("first_gnt", 32'(GNT), 32'h1);
      checkOutput("first_wx", 32'(W_X), 1);
      REQ = '0;
      waitIdle("single");
      checkOutput("single_done", 32'(doneLog[0]), 32'h1);
      checkOutput("single_done_latency", doneCyc[0] - gntCyc[0], 7);
      checkOutput("single_no_err", errLog.size(), 0);

      // Round-robin from reset with all requesters asking.
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      b = gntLog.size();
      d = doneLog.size();
      applyStimulus(4'b1111, 1, 1);
      waitGrants(b + 5, "rr");
      REQ = '0;
      waitIdle("rr");
      checkOutput("rr_g0", 32'(gntLog[b]),     32'h1);
      checkOutput("rr_g1", 32'(gntLog[b + 1]), 32'h2);
      checkOutput("rr_g2", 32'(gntLog[b + 2]), 32'h4);
      checkOutput("rr_g3", 32'(gntLog[b + 3]), 32'h8);
      checkOutput("rr_g4", 32'(gntLog[b + 4]), 32'h1);
      checkOutput("rr_done_count", doneLog.size() - d, 5);

      // Wrap and skip: serve requester 2, then ask with 0 and 1.
      runJob(4'b0100, 1, 1, "wrap_pre");
      b = gntLog.size();
      applyStimulus(4'b0011, 1, 1);
      waitGrants(b + 2, "wrap");
      REQ = '0;
      waitIdle("wrap");
      checkOutput("wrap_g0", 32'(gntLog[b]),     32'h1);
      checkOutput("wrap_g1", 32'(gntLog[b + 1]), 32'h2);

      // START never arrives: ERR 16 cycles after entering WAIT_ST.
      b = gntLog.size(); d = doneLog.size(); e = errLog.size();
      runJob(4'b1000, -1, -1, "st_to");
      checkOutput("st_to_gnt", 32'(gntLog[b]), 32'h8);
      checkOutput("st_to_err", 32'(errLog[e]), 32'h8);
      checkOutput("st_to_latency", errCyc[e] - gntCyc[b], 16);
      checkOutput("st_to_no_done", doneLog.size() - d, 0);

      // Y never arrives: ERR after 1 wait cycle and 16 run cycles.
      b = gntLog.size(); e = errLog.size();
      runJob(4'b0001, 0, -1, "y_to");
      checkOutput("y_to_err", 32'(errLog[e]), 32'h1);
      checkOutput("y_to_latency", errCyc[e] - gntCyc[b], 17);

      // Y on the last counter value still completes.
      b = gntLog.size(); d = doneLog.size(); e = errLog.size();
      runJob(4'b0010, 0, 15, "y_edge");
      checkOutput("y_edge_done", 32'(doneLog[d]), 32'h2);
      checkOutput("y_edge_latency", doneCyc[d] - gntCyc[b], 17);
      checkOutput("y_edge_no_err", errLog.size() - e, 0);

      // Reset while in RUN drops the job silently.
      b = gntLog.size(); d = doneLog.size(); e = errLog.size();
      applyStimulus(4'b0100, 0, -1);
      waitGrants(b + 1, "midrst");
      REQ = '0;
      repeat (4) @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      checkOutput("midrst_gnt", 32'(GNT), 0);
      checkOutput("midrst_wx", 32'(W_X), 0);
      checkOutput("midrst_nrst", 32'(W_NRST), 0);
      RESET = 1'b0;
      repeat (3) @(negedge CLK);
      checkOutput("midrst_no_done", doneLog.size() - d, 0);
      checkOutput("midrst_no_err", errLog.size() - e, 0);
      b = gntLog.size();
      runJob(4'b0011, 1, 1, "resume");
      checkOutput("resume_gnt", 32'(gntLog[b]), 32'h1);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got running, want finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
